// File: rtl/div_share_ctrl.sv
// Shared sequential divider with two round-robin requesters.
// One quotient bit per cycle, fixed latency, signed/unsigned by parameter.
module div_share_ctrl #(
    parameter int a_width  = 16,
    parameter int b_width  = 8,
    parameter int tc_mode  = 0,
    parameter int rem_mode = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         req_valid,
    output logic [1:0]         req_ready,
    input  logic [a_width-1:0] req_a0,
    input  logic [a_width-1:0] req_a1,
    input  logic [b_width-1:0] req_b0,
    input  logic [b_width-1:0] req_b1,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic               rsp_id,
    output logic [a_width-1:0] quotient,
    output logic [b_width-1:0] remainder,
    output logic               divide_by_0,
    output logic               busy
);

    localparam int cnt_w = $clog2(a_width + 1);
    localparam bit tc = (tc_mode != 0);
    localparam bit rm = (rem_mode != 0);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t             state;
    logic               last_grant;
    logic               gnt_idx;
    logic               accept;
    logic [a_width-1:0] sel_a;
    logic [b_width-1:0] sel_b;
    logic               sa_in;
    logic               sb_in;
    logic [a_width-1:0] mag_a;
    logic [b_width-1:0] mag_b;
    logic [a_width-1:0] dz_q;

    logic               sa_r;
    logic               sb_r;
    logic [b_width-1:0] b_r;
    logic [b_width-1:0] bm_r;
    logic [a_width-1:0] q_r;
    logic [b_width-1:0] r_r;
    logic [cnt_w-1:0]   cnt;

    logic [b_width:0]   shifted;
    logic [b_width:0]   diff;
    logic               ge;
    logic [a_width-1:0] q_nxt;
    logic [b_width-1:0] r_nxt;
    logic [a_width-1:0] q_fin;
    logic [b_width-1:0] r_rem;
    logic [b_width-1:0] r_mod;
    logic [b_width-1:0] r_fin;

    // Tie goes to whoever was not served last.
    always_comb begin
        accept  = (state == IDLE) && (req_valid != 2'b00);
        gnt_idx = req_valid[1] & (~req_valid[0] | ~last_grant);
        req_ready = 2'b00;
        if (accept) req_ready = gnt_idx ? 2'b10 : 2'b01;
        sel_a = gnt_idx ? req_a1 : req_a0;
        sel_b = gnt_idx ? req_b1 : req_b0;
        sa_in = tc & sel_a[a_width-1];
        sb_in = tc & sel_b[b_width-1];
        mag_a = sa_in ? -sel_a : sel_a;
        mag_b = sb_in ? -sel_b : sel_b;
        dz_q  = '1;
        if (tc) begin
            dz_q = sel_a[a_width-1] ? {1'b1, {(a_width-1){1'b0}}}
                                    : {1'b0, {(a_width-1){1'b1}}};
        end
    end

    // Restoring step plus sign fix-up applied on the final bit.
    always_comb begin
        shifted = {r_r, q_r[a_width-1]};
        diff    = shifted - {1'b0, bm_r};
        ge      = ~diff[b_width];
        r_nxt   = ge ? diff[b_width-1:0] : shifted[b_width-1:0];
        q_nxt   = {q_r[a_width-2:0], ge};
        q_fin   = (sa_r ^ sb_r) ? -q_nxt : q_nxt;
        r_rem   = sa_r ? -r_nxt : r_nxt;
        r_mod   = r_nxt;
        if (sa_r && sb_r)  r_mod = -r_nxt;
        else if (sa_r)     r_mod = b_r - r_nxt;
        else if (sb_r)     r_mod = b_r + r_nxt;
        r_fin = r_nxt;
        if (r_nxt != '0) r_fin = rm ? r_rem : r_mod;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            last_grant  <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_id      <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            divide_by_0 <= 1'b0;
            busy        <= 1'b0;
            sa_r        <= 1'b0;
            sb_r        <= 1'b0;
            b_r         <= '0;
            bm_r        <= '0;
            q_r         <= '0;
            r_r         <= '0;
            cnt         <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        rsp_id     <= gnt_idx;
                        last_grant <= gnt_idx;
                        busy       <= 1'b1;
                        sa_r       <= sa_in;
                        sb_r       <= sb_in;
                        b_r        <= sel_b;
                        bm_r       <= mag_b;
                        q_r        <= mag_a;
                        r_r        <= '0;
                        cnt        <= cnt_w'(a_width - 1);
                        if (sel_b == '0) begin
                            state       <= DONE;
                            rsp_valid   <= 1'b1;
                            quotient    <= dz_q;
                            remainder   <= sel_a[b_width-1:0];
                            divide_by_0 <= 1'b1;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    q_r <= q_nxt;
                    r_r <= r_nxt;
                    cnt <= cnt - cnt_w'(1);
                    if (cnt == '0) begin
                        state       <= DONE;
                        rsp_valid   <= 1'b1;
                        quotient    <= q_fin;
                        remainder   <= r_fin;
                        divide_by_0 <= 1'b0;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
